adder_arbiter: RTL

Sequencer and two-way round-robin arbiter that shares a single combinational W-bit ripple adder between two requesters. Each requester hands over an operand pair and carry-in on a valid/ready handshake. The block registers the operands, drives them onto the shared adder for one cycle, captures sum and carry-out, then returns the result on that requester's response channel. It sits between the external ripple adder instance and the two client blocks.

---
 rtl/adder_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder between
// two requesters; one operation in flight, result returned on the owner's channel.
module adder_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req0_ci,
  input  logic         req1_ci,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp0_sum,
  output logic [W-1:0] rsp1_sum,
  output logic         rsp0_co,
  output logic         rsp1_co,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_ci,
  input  logic [W-1:0] add_sum,
  input  logic         add_co,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t       state, state_nxt;
  logic         owner, ptr;
  logic         gnt_any, gnt_idx, accept, release_rsp;
  logic [W-1:0] op_a, op_b, res_sum;
  logic         op_ci, res_co;

  assign add_a  = op_a;
  assign add_b  = op_b;
  assign add_ci = op_ci;
  assign busy   = (state != IDLE);

  // Contention goes to ptr; a lone requester is granted regardless of ptr.
  assign gnt_any = req0_valid | req1_valid;
  assign gnt_idx = (req0_valid & req1_valid) ? ptr : req1_valid;

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    release_rsp = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    rsp0_sum    = '0;
    rsp1_sum    = '0;
    rsp0_co     = 1'b0;
    rsp1_co     = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && gnt_any) begin
          req0_ready = ~gnt_idx;
          req1_ready = gnt_idx;
          accept     = 1'b1;
          state_nxt  = ADD;
        end
      end
      ADD: state_nxt = RESP;
      RESP: begin
        if (owner) begin
          rsp1_valid  = 1'b1;
          rsp1_sum    = res_sum;
          rsp1_co     = res_co;
          release_rsp = rsp1_ready;
        end else begin
          rsp0_valid  = 1'b1;
          rsp0_sum    = res_sum;
          rsp0_co     = res_co;
          release_rsp = rsp0_ready;
        end
        if (release_rsp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      ptr     <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_ci   <= 1'b0;
      res_sum <= '0;
      res_co  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= gnt_idx;
        op_a  <= gnt_idx ? req1_a  : req0_a;
        op_b  <= gnt_idx ? req1_b  : req0_b;
        op_ci <= gnt_idx ? req1_ci : req0_ci;
      end
      if (state == ADD) begin
        res_sum <= add_sum;
        res_co  <= add_co;
      end
      if (release_rsp) ptr <= ~owner;
    end
  end

endmodule
